multicycle_main_fsm: RTL
========================

Name: multicycle_main_fsm

Overview:
- Moore control FSM for the multicycle MIPS datapath. It sits directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- Drives all datapath enables and muxes from the 6-bit opcode.
- Its 2-bit ALUOp feeds the ALU decoder's Op input:
  - 00 = add
  - 01 = subtract
  - 10 = use the funct field

Parameters:
- STATE_BITS, 4, width of the state register; must be >= 4. Upper bits beyond 4 are tied to zero.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  instruction opcode field, taken from the instruction register.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load enable.
- RegDst  out  1  destination register select: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = Data.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  out  2  to the ALU decoder Op input.
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- Branch  out  1  gated with Zero downstream to form the PC enable.
- PCWrite  out  1  unconditional PC enable.
- IllegalOp  out  1  one-cycle pulse when Decode sees an unrecognised opcode.

Behaviour:
- The state register updates on the rising edge of clk.
- reset asynchronously forces state FETCH.
- While reset is high, IRWrite, PCWrite, MemWrite, RegWrite, Branch and IllegalOp are forced 0. All other outputs take their FETCH values.
- Outputs are purely a function of state (Moore). The one exception is IllegalOp, which also depends on Op in DECODE.
- Output values not listed for a state are 0.

States and required outputs:
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target). Next state by opcode:
  - Op=100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXECUTE.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEXEC.
  - 000010 (j) -> JUMP.
  - Any other opcode -> FETCH, with IllegalOp=1 during this DECODE cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMREAD; sw -> MEMWRITE. The opcode is sampled this cycle.
- MEMREAD: IorD=1. Next: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWRITE: IorD=1, MemWrite=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.

Latencies in cycles, including FETCH:
- lw = 5; sw = 4; R-type = 4; addi = 4; beq = 3; j = 3; illegal opcode = 2.

Boundary conditions:
- Op may change after DECODE. Only the DECODE and MEMADR cycles sample it.
- An unreachable or undefined state encoding recovers to FETCH on the next edge, with all enables 0 in that cycle.
- Reset asserted mid-instruction aborts it immediately. No write enable may glitch high during the abort.
- Reset release is sampled at the next rising edge; the FSM leaves FETCH for DECODE on the first edge after deassertion.

Optional Feature:
- Macro: MULTICYCLE_MAIN_FSM_BNE_EN.
- Defined:
  - Adds output BranchNe (1 bit).
  - In DECODE, Op=000101 (bne) -> BNESTATE. This opcode is then not illegal.
  - BNESTATE outputs are identical to BRANCH, except Branch=0 and BranchNe=1. Next: FETCH. Latency 3 cycles.
- Undefined:
  - No BranchNe port.
  - 000101 is treated as illegal: IllegalOp pulses and the FSM returns to FETCH.

Test Plan:
- Reset and illegal opcode:
  - Assert reset mid-MEMREAD of an lw -> state FETCH immediately; IRWrite=PCWrite=RegWrite=MemWrite=0 while reset is high.
  - After release with Op=100011, the next edge enters DECODE.
- lw, Op=100011: state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - ALUOp sequence 00, 00, 00, xx, xx.
  - RegWrite=1 and MemtoReg=1 only in cycle 5.
- sw and R-type:
  - sw (101011): MemWrite=1 and IorD=1 only in cycle 4.
  - R-type (000000): ALUOp=10 in cycle 3, then RegDst=1 and RegWrite=1 in cycle 4.
- beq and j:
  - beq (000100): Branch=1, ALUOp=01, PCSrc=01 in cycle 3.
  - j (000010): PCWrite=1, PCSrc=10 in cycle 3. Both return to FETCH in cycle 4.
- addi and illegal:
  - addi (001000): ALUSrcB=10 in cycle 3, RegWrite=1 with RegDst=0 in cycle 4.
  - Op=111111: IllegalOp=1 in DECODE only, then FETCH.
- Op stability: change Op from 100011 to 101011 during MEMREAD of an lw -> the sequence is unaffected and MemWrite stays 0.
- Macro test: with MULTICYCLE_MAIN_FSM_BNE_EN defined, Op=000101 gives BranchNe=1, Branch=0 in cycle 3 and IllegalOp=0. Without the macro, IllegalOp=1.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | multicycle_main_fsm: Moore control FSM for the multicycle MIPS datapath. |
// | Optional bne support: define MULTICYCLE_MAIN_FSM_BNE_EN.                 |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module multicycle_main_fsm #(
  parameter int STATE_BITS = 4  // must be >= 4; upper bits stay zero
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       Branch,
  output logic       PCWrite,
  output logic       IllegalOp
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
  ,
  output logic       BranchNe
`endif
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [STATE_BITS-1:0] {
    FETCH    = 0,
    DECODE   = 1,
    MEMADR   = 2,
    MEMREAD  = 3,
    MEMWB    = 4,
    MEMWRITE = 5,
    EXECUTE  = 6,
    ALUWB    = 7,
    BRANCH   = 8,
    ADDIEXEC = 9,
    ADDIWB   = 10,
    JUMP     = 11
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
    ,
    BNESTATE = 12
`endif
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       branch;
    logic       pc_write;
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
    logic       branch_ne;
`endif
  } ctrl_t;

  // Control word for a given state; anything not listed stays 0.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      DECODE:   c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMREAD:  c.iord = 1'b1;
      MEMWB: begin
        c.memto_reg = 1'b1;
        c.reg_write = 1'b1;
      end
      MEMWRITE: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB:   c.reg_write = 1'b1;
      JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
      BNESTATE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch_ne = 1'b1;
      end
`endif
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_w;
  logic   state_ok_w;
  logic   en_mask_w;

  always_comb begin
    state_d    = FETCH;
    illegal_w  = 1'b0;
    state_ok_w = 1'b1;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
          OP_BNE:       state_d = BNESTATE;
`endif
          default: begin
            state_d   = FETCH;
            illegal_w = 1'b1;
          end
        endcase
      end
      // Opcode is re-sampled here; a non-memory opcode abandons the access.
      MEMADR: begin
        if (Op == OP_LW)      state_d = MEMREAD;
        else if (Op == OP_SW) state_d = MEMWRITE;
        else                  state_d = FETCH;
      end
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
      BNESTATE: state_d = FETCH;
`endif
      default: begin
        state_d    = FETCH;
        state_ok_w = 1'b0;
      end
    endcase
    ctrl_d = decode_ctrl(state_d);
  end

  // Control word is registered alongside the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= decode_ctrl(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Enables are held low during reset and in any corrupted state encoding.
  assign en_mask_w = ~reset & state_ok_w;

  assign IorD      = ctrl_q.iord;
  assign RegDst    = ctrl_q.reg_dst;
  assign MemtoReg  = ctrl_q.memto_reg;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ALUOp     = ctrl_q.alu_op;
  assign PCSrc     = ctrl_q.pc_src;
  assign MemWrite  = ctrl_q.mem_write & en_mask_w;
  assign IRWrite   = ctrl_q.ir_write  & en_mask_w;
  assign RegWrite  = ctrl_q.reg_write & en_mask_w;
  assign Branch    = ctrl_q.branch    & en_mask_w;
  assign PCWrite   = ctrl_q.pc_write  & en_mask_w;
  assign IllegalOp = illegal_w & ~reset;
`ifdef MULTICYCLE_MAIN_FSM_BNE_EN
  assign BranchNe  = ctrl_q.branch_ne & en_mask_w;
`endif

endmodule
`default_nettype wire
